// File: rtl/lfsr_frame_packer_pkg.sv
// Shared FFT-front-end types: default widths, packer FSM states and the complex sample payload.
package lfsr_frame_packer_pkg;

  localparam int unsigned DEF_DATA_W    = 16;
  localparam int unsigned DEF_FRAME_LEN = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CAP_RE = 2'd1,
    CAP_IM = 2'd2,
    DRAIN  = 2'd3
  } state_e;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] re;
    logic [DEF_DATA_W-1:0] im;
    logic                  last;
  } sample_t;

  localparam int unsigned SAMPLE_W = $bits(sample_t);

endpackage

// File: rtl/sample_fifo_fwft.sv
// First-word-fall-through FIFO; when empty the output holds the last popped word.
module sample_fifo_fwft #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] last_q;
  logic             push_en;
  logic             pop_en;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign pop_en  = pop & ~empty;
  // A pop in the same cycle frees the slot being written, so a full FIFO still accepts.
  assign push_en = push & (~full | pop_en);
  assign count   = count_q;
  assign dout    = empty ? last_q : mem[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_en) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        last_q   <= mem[rd_ptr_q];
      end
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: it is only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/lfsr_frame_packer.sv
// Packs consecutive LFSR words into (re, im) samples and streams fixed-length frames
// through a small FWFT FIFO; pairs arriving while the FIFO is full are dropped and counted.
module lfsr_frame_packer
  import lfsr_frame_packer_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned FRAME_LEN  = DEF_FRAME_LEN,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [DATA_W-1:0] lfsr_in,
  output logic [DATA_W-1:0] out_re,
  output logic [DATA_W-1:0] out_im,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int unsigned IDX_W  = $clog2(FRAME_LEN);
  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]        rst_sync_q;
  logic              rst_n;
  state_e            state_q;
  state_e            state_d;
  logic [DATA_W-1:0] re_q;
  logic [IDX_W-1:0]  idx_q;
  logic [CNT_W-1:0]  drop_cnt_q;
  logic [CNT_W-1:0]  frame_cnt_q;

  logic              fifo_full;
  logic              fifo_empty;
  logic [FCNT_W-1:0] fifo_count;
  logic [SAMPLE_W-1:0] fifo_dout;
  sample_t           wr_sample;
  sample_t           head;

  logic              push_c;
  logic              pop_c;
  logic              push_ok_c;
  logic              push_drop_c;
  logic              last_idx_c;

  // Reset asserts asynchronously, releases two clock edges after resetn rises.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rst_sync_q <= '0;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  assign push_c      = (state_q == CAP_IM);
  assign pop_c       = out_valid & out_ready;
  assign push_ok_c   = push_c & (~fifo_full | pop_c);
  assign push_drop_c = push_c & ~push_ok_c;
  assign last_idx_c  = (idx_q == IDX_W'(FRAME_LEN - 1));

  assign wr_sample.re   = re_q;
  assign wr_sample.im   = lfsr_in;
  assign wr_sample.last = last_idx_c;

  sample_fifo_fwft #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_c),
    .pop   (pop_c),
    .din   (wr_sample),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign head      = fifo_dout;
  assign out_valid = (fifo_count != '0);
  assign out_re    = head.re;
  assign out_im    = head.im;
  assign out_last  = head.last;
  assign busy      = (state_q != IDLE);
  assign drop_cnt  = drop_cnt_q;
  assign frame_cnt = frame_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CAP_RE;
      CAP_RE:  state_d = CAP_IM;
      // A refused pair is not retried; the next pair takes the same index.
      CAP_IM:  state_d = (push_ok_c && last_idx_c) ? DRAIN : CAP_RE;
      DRAIN:   if (fifo_empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      re_q        <= '0;
      idx_q       <= '0;
      drop_cnt_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      if (state_q == CAP_RE) re_q <= lfsr_in;
      if (push_ok_c) idx_q <= last_idx_c ? '0 : idx_q + IDX_W'(1);
      if (push_drop_c && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
      if (pop_c && head.last) frame_cnt_q <= frame_cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: doc/lfsr_frame_packer.md
Name: lfsr_frame_packer

Overview:
- Sits directly downstream of the 16-bit LFSR test-pattern generator in the FFT datapath.
- Packs consecutive LFSR words into complex samples (real, imag) and emits them as fixed-length frames over a valid/ready stream into the FFT input buffer.
- A small FIFO absorbs FFT back-pressure. The LFSR has no enable, so a pair that arrives while the FIFO is full is dropped and counted; the frame index does not advance.

Parameters:
- DATA_W, 16, width of LFSR word and of each real/imag component.
- FRAME_LEN, 64, complex samples per frame; power of 2, ≥2.
- FIFO_DEPTH, 4, sample FIFO entries; power of 2, ≥2.
- CNT_W, 16, width of drop and frame counters.

Ports:
- clk  in  1  single clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  begin one frame; honoured only in IDLE.
- lfsr_in  in  DATA_W  LFSR output word, new value every cycle.
- out_re  out  DATA_W  real part of head sample.
- out_im  out  DATA_W  imag part of head sample.
- out_valid  out  1  head sample valid.
- out_ready  in  1  consumer accepts when out_valid&out_ready.
- out_last  out  1  head sample is index FRAME_LEN-1.
- busy  out  1  state != IDLE.
- drop_cnt  out  CNT_W  dropped pairs; saturates at all-ones.
- frame_cnt  out  CNT_W  completed frames (last beat accepted); wraps.

Behaviour:
- Reset (async assert, sync deassert by clk): state=IDLE; FIFO empty; sample index=0.
  - Outputs: out_valid=0, out_last=0, out_re=out_im=0, busy=0, drop_cnt=0, frame_cnt=0.
- FSM states: IDLE, CAP_RE, CAP_IM, DRAIN.
  - IDLE: start=1 at edge k -> CAP_RE.
  - CAP_RE: at edge k+1 register lfsr_in as re -> CAP_IM.
  - CAP_IM: at edge k+2 push {re, lfsr_in, last=(idx==FRAME_LEN-1)}.
    - Push accepted: idx++ (wraps to 0 after FRAME_LEN-1). Go to DRAIN if last, else CAP_RE.
    - Push refused: drop_cnt++ (saturating); idx unchanged -> CAP_RE (retry with the next pair).
  - DRAIN: stay until the FIFO is empty and no pop is pending -> IDLE.
- Push acceptance: accepted if count<FIFO_DEPTH, or if a pop happens in the same cycle. Full + simultaneous pop + push: count unchanged, no drop.
- FIFO: first-word-fall-through.
  - out_valid = (count!=0); out_re/out_im/out_last are taken from the head entry.
  - First out_valid is high after edge k+2, i.e. 2 cycles after start was sampled.
  - Empty FIFO: out_re/out_im/out_last hold the last popped values (0 after reset).
  - Read/write pointers are log2(FIFO_DEPTH) bits, wrap naturally; count is log2+1 bits.
- Stream rules: out_valid never deasserts without a handshake; head data stable while out_valid&!out_ready.
- frame_cnt increments on the handshake cycle of a beat with out_last=1.
- start while busy: ignored, no queuing.
- Sustained rate: one sample per 2 cycles. A consumer with permanent out_ready=1 sees zero drops.
- Reset mid-frame: FIFO content discarded, idx=0, counters cleared. No partial frame is resumed.
- drop_cnt and frame_cnt are not cleared by start, only by reset.

Decomposition:
- Shared FFT package holds:
  - DATA_W and FRAME_LEN defaults;
  - the state enum (IDLE, CAP_RE, CAP_IM, DRAIN);
  - the packed sample struct {re, im, last}.
- One sub-module: sample_fifo_fwft (parameterised width/depth; push, pop, full, empty, count). The FSM and counters stay in lfsr_frame_packer.

Test Plan:
- Basic frame, FRAME_LEN=4, out_ready=1, lfsr_in ramps 0x0001,0x0002,... from the CAP_RE cycle, pulse start:
  - out_valid rises 2 cycles after start;
  - beats (1,2),(3,4),(5,6),(7,8), out_last only on (7,8);
  - frame_cnt=1, busy falls after the last beat, drop_cnt=0.
- Back-pressure, FIFO_DEPTH=4, out_ready=0 throughout:
  - 4 pairs accepted, then each further pair increments drop_cnt (5 extra pairs -> drop_cnt=5);
  - raise out_ready: the 4 buffered beats drain in order and the frame completes with the correct last.
- Full + pop + push same cycle: hold the FIFO full, assert out_ready exactly in the CAP_IM cycle -> no drop, count stays 4.
- Holding: out_ready toggles 1-0-1 during valid -> out_re/out_im/out_last stable while stalled; no duplicated or lost beats (scoreboard compare against the ramp).
- Start while busy: second start pulse mid-frame -> ignored, exactly FRAME_LEN beats, frame_cnt=1.
- Async reset mid-frame (after 2 beats) -> out_valid=0 immediately (no clock edge), counters=0; a new start produces a fresh frame from idx 0.
